// File: rtl/nvdla_glb_csb_pkg.sv
// nvdla_glb_csb_pkg: CSB packet layout, widths and helpers shared by the GLB CSB arbiter.
package nvdla_glb_csb_pkg;
  localparam int REQ_PD_W        = 63;
  localparam int RESP_PD_W       = 34;
  localparam int REQ_ADDR_LSB    = 0;
  localparam int REQ_WDAT_LSB    = 22;
  localparam int REQ_WRITE_BIT   = 54;
  localparam int REQ_NPOSTED_BIT = 55;
  localparam int REQ_SRCPRIV_BIT = 56;
  localparam int REQ_WRBE_LSB    = 57;
  localparam int REQ_LEVEL_LSB   = 61;
  localparam int RESP_RDAT_LSB   = 0;
  localparam int RESP_ERROR_BIT  = 32;
  localparam int RESP_IS_WR_BIT  = 33;
  localparam logic RESP_ID_RD    = 1'b0;
  localparam logic RESP_ID_WR    = 1'b1;
  // Reads and non-posted writes are answered by the target; posted writes are not.
  function automatic logic req_rexp(input logic [REQ_PD_W-1:0] pd);
    return !pd[REQ_WRITE_BIT] | pd[REQ_NPOSTED_BIT];
  endfunction
endpackage

// File: rtl/nvdla_glb_csb_idfifo.sv
// nvdla_glb_csb_idfifo: 1-bit in-order master-ID FIFO with registered occupancy count.
module nvdla_glb_csb_idfifo
  import nvdla_glb_csb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= wp_q + AW'(1);
      end
      if (pop_i) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign dout_o  = mem_q[rp_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/nvdla_glb_csb_arb.sv
// nvdla_glb_csb_arb: round-robin two-master CSB arbiter in front of one GLB CSB target,
// routing in-order target responses back to the issuing master.
module nvdla_glb_csb_arb
  import nvdla_glb_csb_pkg::*;
#(
  parameter int OUTS_DEPTH = 4
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 m0_req_pvld,
  output logic                 m0_req_prdy,
  input  logic [REQ_PD_W-1:0]  m0_req_pd,
  input  logic                 m1_req_pvld,
  output logic                 m1_req_prdy,
  input  logic [REQ_PD_W-1:0]  m1_req_pd,
  output logic                 m0_resp_valid,
  output logic [RESP_PD_W-1:0] m0_resp_pd,
  output logic                 m1_resp_valid,
  output logic [RESP_PD_W-1:0] m1_resp_pd,
  output logic                 tgt_req_pvld,
  input  logic                 tgt_req_prdy,
  output logic [REQ_PD_W-1:0]  tgt_req_pd,
  input  logic                 tgt_resp_valid,
  input  logic [RESP_PD_W-1:0] tgt_resp_pd,
  output logic                 err_unexp_resp
);
  logic                 out_free, elig0, elig1, gnt0, gnt1, accept, full, empty, head, pop;
  logic                 ptr_q, ptr_d, req_vld_q, req_vld_d;
  logic [REQ_PD_W-1:0]  req_pd_q, req_pd_d, sel_pd;
  logic                 r0_vld_q, r1_vld_q, err_q;
  logic [RESP_PD_W-1:0] r0_pd_q, r1_pd_q;
  assign out_free = !req_vld_q | tgt_req_prdy;
  assign elig0 = m0_req_pvld & (!req_rexp(m0_req_pd) | !full);
  assign elig1 = m1_req_pvld & (!req_rexp(m1_req_pd) | !full);
  // ptr_q==1 gives m1 priority; a lone eligible master always wins.
  assign gnt0 = elig0 & (!elig1 | !ptr_q);
  assign gnt1 = elig1 & (!elig0 | ptr_q);
  assign m0_req_prdy = nvdla_core_rstn & out_free & gnt0;
  assign m1_req_prdy = nvdla_core_rstn & out_free & gnt1;
  assign accept = m0_req_prdy | m1_req_prdy;
  assign sel_pd = gnt1 ? m1_req_pd : m0_req_pd;
  assign pop = tgt_resp_valid & !empty;
  always_comb begin
    ptr_d     = accept ? gnt0 : ptr_q;
    req_vld_d = accept ? 1'b1 : (tgt_req_prdy ? 1'b0 : req_vld_q);
    req_pd_d  = accept ? sel_pd : req_pd_q;
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      ptr_q     <= 1'b0;
      req_vld_q <= 1'b0;
      req_pd_q  <= '0;
      r0_vld_q  <= 1'b0;
      r1_vld_q  <= 1'b0;
      r0_pd_q   <= '0;
      r1_pd_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      req_vld_q <= req_vld_d;
      req_pd_q  <= req_pd_d;
      r0_vld_q  <= pop & !head;
      r1_vld_q  <= pop & head;
      if (pop & !head) r0_pd_q <= tgt_resp_pd;
      if (pop & head) r1_pd_q <= tgt_resp_pd;
      if (tgt_resp_valid & empty) err_q <= 1'b1;
    end
  nvdla_glb_csb_idfifo #(.DEPTH(OUTS_DEPTH)) u_idfifo (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .push_i         (accept & req_rexp(sel_pd)),
    .pop_i          (pop),
    .din_i          (gnt1),
    .dout_o         (head),
    .full_o         (full),
    .empty_o        (empty)
  );
  assign tgt_req_pvld   = req_vld_q;
  assign tgt_req_pd     = req_pd_q;
  assign m0_resp_valid  = r0_vld_q;
  assign m1_resp_valid  = r1_vld_q;
  assign m0_resp_pd     = r0_pd_q;
  assign m1_resp_pd     = r1_pd_q;
  assign err_unexp_resp = err_q;
endmodule

// File: tb/tb_nvdla_glb_csb_arb.sv
// tb_nvdla_glb_csb_arb: directed vectors with hand-computed expectations for the GLB CSB arbiter.
module tb_nvdla_glb_csb_arb;
  logic        clk = 0, rstn = 0;
  logic        m0_pvld = 0, m1_pvld = 0, tgt_prdy = 0, tgt_rv = 0;
  logic [62:0] m0_pd = '0, m1_pd = '0;
  logic [33:0] tgt_rpd = '0;
  logic        m0_prdy, m1_prdy, m0_rv, m1_rv, tgt_pvld, err;
  logic [33:0] m0_rpd, m1_rpd;
  logic [62:0] tgt_pd;
  int          n_vec = 0, n_err = 0;
  logic [62:0] pa, pb, pc, pd, pe, pw, q0, q1;

  nvdla_glb_csb_arb #(.OUTS_DEPTH(4)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .m0_req_pvld(m0_pvld), .m0_req_prdy(m0_prdy), .m0_req_pd(m0_pd),
    .m1_req_pvld(m1_pvld), .m1_req_prdy(m1_prdy), .m1_req_pd(m1_pd),
    .m0_resp_valid(m0_rv), .m0_resp_pd(m0_rpd),
    .m1_resp_valid(m1_rv), .m1_resp_pd(m1_rpd),
    .tgt_req_pvld(tgt_pvld), .tgt_req_prdy(tgt_prdy), .tgt_req_pd(tgt_pd),
    .tgt_resp_valid(tgt_rv), .tgt_resp_pd(tgt_rpd),
    .err_unexp_resp(err)
  );

  always #5 clk = ~clk;

  function automatic logic [62:0] mk(input logic [21:0] a, input logic [31:0] d,
                                     input logic w, input logic np);
    return {7'b0, np, w, d, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    m0_pvld = 0; m1_pvld = 0; tgt_rv = 0; tgt_prdy = 1;
    rstn = 0;
    step();
    rstn = 1;
  endtask

  initial begin
    pa = mk(22'h100, 32'h0, 0, 0);
    // reset state, with a master already requesting
    m0_pvld = 1; m0_pd = pa; tgt_prdy = 1;
    settle();
    chk("rst_m0_prdy", m0_prdy, 0);
    chk("rst_tgt_pvld", tgt_pvld, 0);
    chk("rst_tgt_pd", tgt_pd, 0);
    chk("rst_resp_v", {m0_rv, m1_rv}, 0);
    chk("rst_err", err, 0);
    do_reset();

    // single m0 read, target answers two cycles after issue
    m0_pvld = 1; m0_pd = pa;
    settle();
    chk("t1_prdy", {m0_prdy, m1_prdy}, 2'b10);
    step();
    m0_pvld = 0;
    chk("t1_issue_v", tgt_pvld, 1);
    chk("t1_issue_pd", tgt_pd, pa);
    step();
    chk("t1_drain", tgt_pvld, 0);
    tgt_rv = 1; tgt_rpd = 34'h0_DEADBEEF;
    step();
    tgt_rv = 0;
    chk("t1_resp_v", {m0_rv, m1_rv}, 2'b10);
    chk("t1_resp_pd", m0_rpd, 34'h0_DEADBEEF);
    step();
    chk("t1_pulse", {m0_rv, m1_rv}, 2'b00);
    chk("t1_hold", m0_rpd, 34'h0_DEADBEEF);
    chk("t1_no_err", err, 0);

    // both masters read continuously: grants alternate starting at m0
    do_reset();
    q0 = mk(22'h010, 0, 0, 0); q1 = mk(22'h020, 0, 0, 0);
    m0_pvld = 1; m0_pd = q0; m1_pvld = 1; m1_pd = q1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t2_gnt%0d", i), {m0_prdy, m1_prdy}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
      chk($sformatf("t2_pd%0d", i), tgt_pd, (i % 2 == 0) ? q0 : q1);
    end
    settle();
    chk("t2_full", {m0_prdy, m1_prdy}, 2'b00);
    m0_pvld = 0; m1_pvld = 0;
    for (int i = 0; i < 4; i++) begin
      tgt_rv = 1; tgt_rpd = 34'(32'hA000 + i);
      step();
      chk($sformatf("t2_rv%0d", i), {m0_rv, m1_rv}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("t2_rpd%0d", i), (i % 2 == 0) ? m0_rpd : m1_rpd, 34'(32'hA000 + i));
    end
    tgt_rv = 0;
    step();
    chk("t2_err", err, 0);

    // posted write from m1, then a stray response
    pw = mk(22'h030, 32'h1234, 1, 0);
    m1_pvld = 1; m1_pd = pw;
    settle();
    chk("t3_prdy", {m0_prdy, m1_prdy}, 2'b01);
    step();
    m1_pvld = 0;
    chk("t3_pd", tgt_pd, pw);
    step();
    tgt_rv = 1; tgt_rpd = 34'h5;
    step();
    tgt_rv = 0;
    chk("t3_no_resp", {m0_rv, m1_rv}, 2'b00);
    chk("t3_err", err, 1);
    step(); step();
    chk("t3_err_sticky", err, 1);
    do_reset();
    chk("t3_err_clr", err, 0);

    // backpressure for 5 cycles, then fill the ID FIFO
    pa = mk(22'h0A, 0, 0, 0); pb = mk(22'h0B, 0, 0, 0); pc = mk(22'h0C, 0, 0, 0);
    pd = mk(22'h0D, 0, 0, 0); pe = mk(22'h0E, 0, 0, 0); pw = mk(22'h0F, 32'h77, 1, 0);
    m0_pvld = 1; m0_pd = pa;
    step();
    tgt_prdy = 0; m0_pd = pb; m1_pvld = 1; m1_pd = pc;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("t4_stall_prdy%0d", i), {m0_prdy, m1_prdy}, 2'b00);
      chk($sformatf("t4_stall_pd%0d", i), {tgt_pvld, tgt_pd}, {1'b1, pa});
      step();
    end
    tgt_prdy = 1;
    settle();
    chk("t4_release", {m0_prdy, m1_prdy}, 2'b01);
    step();
    chk("t4_pd_c", tgt_pd, pc);
    m1_pvld = 0;
    settle();
    chk("t4_prdy_b", m0_prdy, 1);
    step();
    chk("t4_pd_b", tgt_pd, pb);
    m0_pd = pd;
    step();
    chk("t4_pd_d", tgt_pd, pd);
    m0_pd = pe; m1_pvld = 1; m1_pd = pw;
    settle();
    chk("t5_blocked", {m0_prdy, m1_prdy}, 2'b01);
    step();
    chk("t5_posted_pd", tgt_pd, pw);
    m1_pvld = 0;
    tgt_rv = 1; tgt_rpd = 34'h2_0000_00AA;
    settle();
    chk("t5_no_bypass", m0_prdy, 0);
    step();
    tgt_rv = 0;
    chk("t5_resp_a", {m0_rv, m1_rv, m0_rpd}, {2'b10, 34'h2_0000_00AA});
    chk("t5_unblocked", m0_prdy, 1);
    step();
    m0_pvld = 0;
    chk("t5_pd_e", tgt_pd, pe);

    // reset mid-flight: output cleared, late response is unexpected
    tgt_prdy = 0; m0_pvld = 1; m0_pd = pa;
    step();
    m0_pvld = 0;
    rstn = 0;
    settle();
    chk("t6_async_clr", {tgt_pvld, tgt_pd}, 0);
    step();
    rstn = 1; tgt_prdy = 1;
    tgt_rv = 1; tgt_rpd = 34'h1;
    step();
    tgt_rv = 0;
    chk("t6_late_resp", {m0_rv, m1_rv, err}, 3'b001);
    do_reset();
    chk("t6_err_clr", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/nvdla_glb_csb_arb.md
# nvdla_glb_csb_arb

Two-master CSB arbiter placed in front of a single GLB CSB target port, such as the global falcon/GEC register stub. It shares that target between the host CSB path (master 0) and the falcon-side path (master 1). Scheduling is round-robin. A small in-order ID FIFO tracks outstanding requests that expect a response, and each target response is routed back to the master that issued the request.

## Interface
- OUTS_DEPTH, 4, maximum outstanding response-expecting requests (power of 2, ≥2)
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- m0_req_pvld / m1_req_pvld  in  1  master request valid
- m0_req_prdy / m1_req_prdy  out  1  master request ready
- m0_req_pd / m1_req_pd  in  63  csb2xx_16m_be_lvl packet: addr[21:0], wdat[53:22], write[54], nposted[55], srcpriv[56], wrbe[60:57], level[62:61]
- m0_resp_valid / m1_resp_valid  out  1  response pulse to master
- m0_resp_pd / m1_resp_pd  out  34  xx2csb resp: rdat[31:0], error[32], is_wr[33]
- tgt_req_pvld  out  1  request to target
- tgt_req_prdy  in  1  target ready
- tgt_req_pd  out  63  forwarded request packet, unmodified
- tgt_resp_valid  in  1  target response pulse (no backpressure)
- tgt_resp_pd  in  34  target response packet
- err_unexp_resp  out  1  sticky: a response arrived with no outstanding entry

## Operation
- Response expected (rexp) when pd[54]==0 (read), or when pd[54]==1 and pd[55]==1 (non-posted write). Posted writes get no response.
- Output stage: one request register (valid, pd). `out_free = !tgt_req_pvld | tgt_req_prdy`.
- Eligible master: pvld=1, and, if rexp, the FIFO count is < OUTS_DEPTH.
  - Full-FIFO check uses the registered count. There is no bypass for a same-cycle pop.
- Round-robin grant among eligible masters when out_free.
  - Priority pointer resets to m0.
  - After a grant to mX, the pointer moves to the other master.
  - A lone eligible master is granted regardless of the pointer.
- mX_req_prdy = out_free & grant==X. The non-granted master's prdy is 0.
- On accept: load the output register with the pd. If rexp, push the master ID (1 bit) into the ID FIFO.
- On tgt_resp_valid with the FIFO non-empty:
  - pop the head ID;
  - next cycle drive m{ID}_resp_valid=1 with m{ID}_resp_pd = tgt_resp_pd (registered).
- On tgt_resp_valid with the FIFO empty: drop the response, set err_unexp_resp. It is cleared only by reset.
- Push and pop in the same cycle: count unchanged; both take effect.
- Responses are strictly in order (the CSB target returns responses in issue order).

## Timing
- Reset values: all *_prdy, *_resp_valid, tgt_req_pvld, err_unexp_resp = 0; all pd outputs = 0; FIFO empty; pointer = m0.
  - prdy is combinational and becomes 1 once reset is released and out_free is true.
- Request latency: accept at cycle N → tgt_req_pvld=1 at N+1. pd is held stable while tgt_req_prdy=0.
- Throughput: one request per cycle while tgt_req_prdy stays 1.
- Response latency: tgt_resp_valid at cycle M → mX_resp_valid at M+1 for exactly one cycle.
  - mX_resp_pd holds its value until the next response to that master.
- Reset mid-transaction: asserting nvdla_core_rstn low immediately clears the output register, the FIFO and the response registers. In-flight target responses that arrive after reset flag err_unexp_resp.

## Structure
- Shared package nvdla_glb_csb_pkg holds:
  - field offsets for the 63-bit request and 34-bit response;
  - localparams for the widths (REQ_PD_W=63, RESP_PD_W=34);
  - the resp-ID bit encoding (0=read, 1=write).
- Sub-module nvdla_glb_csb_idfifo: synchronous FIFO, 1-bit wide, OUTS_DEPTH deep, registered count, push/pop/full/empty. The arbiter and output stage live in the top module.

## Test plan
- Single m0 read, tgt_req_prdy=1, target responds 2 cycles after issue with rdat=0xDEADBEEF → m0_resp_valid pulse carrying 0x0_DEADBEEF; m1 receives nothing.
- Both masters assert continuously with reads, target always ready → grants alternate m0,m1,m0,m1. Responses return in order to the matching master.
- m1 issues posted write (pd[55]=0) → forwarded to the target; FIFO count stays 0; no response to m1.
- Target holds tgt_req_prdy=0 for 5 cycles → tgt_req_pd stable, both master prdy=0; first accept on the cycle prdy rises.
- With OUTS_DEPTH=4, issue 4 reads without responses → 5th read blocked (prdy=0), while a posted write from the other master still passes. One response pops an entry and the read is accepted next cycle.
- tgt_resp_valid with empty FIFO → err_unexp_resp=1 and stays 1; no master response; cleared by reset.
